if_stage_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and runs a req/ack handshake to a multi-cycle instruction memory. It buffers one fetched instruction with its PC+4 and applies branch redirects coming back from EXE. It honours the pipeline freeze so no instruction is lost or duplicated while the downstream register holds.

---
 rtl/if_stage_fetch.sv | 172 +++++++++++++++++
 tb/tb_if_stage_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// ---------------------------------------------------------------------------
// if_stage_fetch
//
// Instruction-fetch stage feeding the IF/ID pipeline register. It owns the
// PC, runs a single-outstanding req/ack handshake to a multi-cycle
// instruction memory, buffers one fetched instruction together with its
// PC + PC_STEP, and applies branch redirects coming back from EXE. While the
// downstream register is frozen the buffered instruction is held, so nothing
// is lost or duplicated.
//
// Parameters
//   RESET_PC        PC loaded on reset
//   PC_STEP         byte increment between sequential instructions
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   freeze          downstream hold; IF/ID load-enable is low while set
//   branchTaken     one-cycle redirect pulse from EXE
//   branchAddr      redirect target, valid while branchTaken=1
//   memReq          instruction-memory request
//   memAddr         request address, stable until the matching ack
//   memAck          one-cycle completion pulse, memRdata valid with it
//   memRdata        instruction word returned by memory
//   pcOut           address of the buffered instruction + PC_STEP
//   instructionOut  buffered instruction
//   valid           buffer holds a live instruction (0 = bubble)
// ---------------------------------------------------------------------------
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic [31:0] pcOut,
    output logic [31:0] instructionOut,
    output logic        valid
);

    // REQ : request outstanding at r_pc
    // HAVE: buffer holds an instruction, no request outstanding
    // DROP: waiting out a request at r_drop_addr whose data will be thrown away
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HAVE = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_valid;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_drop_next;
    logic        w_valid_next;
    logic        w_load_buf;
    logic [31:0] w_pc_inc;

    // Wraps modulo 2^32 by construction of the 32-bit sum.
    assign w_pc_inc = r_pc + PC_STEP;

    // -----------------------------------------------------------------------
    // Next-state / next-register logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_drop_next  = r_drop_addr;
        w_valid_next = r_valid;
        w_load_buf   = 1'b0;

        unique case (r_state)
            S_REQ: begin
                // freeze is deliberately ignored here: the buffer is empty.
                if (memAck) begin
                    if (branchTaken) begin
                        // Returned word is on the wrong path; refetch at target.
                        w_pc_next = branchAddr;
                    end else begin
                        w_load_buf   = 1'b1;
                        w_pc_next    = w_pc_inc;
                        w_valid_next = 1'b1;
                        w_state_next = S_HAVE;
                    end
                end else if (branchTaken) begin
                    // The request cannot be withdrawn, so keep presenting its
                    // address until it completes, then discard the data.
                    w_drop_next  = r_pc;
                    w_pc_next    = branchAddr;
                    w_state_next = S_DROP;
                end
            end

            S_HAVE: begin
                // Branch beats freeze: the buffered instruction is wrong-path.
                if (branchTaken) begin
                    w_valid_next = 1'b0;
                    w_pc_next    = branchAddr;
                    w_state_next = S_REQ;
                end else if (!freeze) begin
                    // IF/ID captures the buffer at this edge.
                    w_valid_next = 1'b0;
                    w_state_next = S_REQ;
                end
            end

            S_DROP: begin
                if (branchTaken) begin
                    w_pc_next = branchAddr;
                end
                if (memAck) begin
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_valid_next = 1'b0;
                w_state_next = S_REQ;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_drop_addr <= 32'h0;
            r_pc_out    <= 32'h0;
            r_instr     <= 32'h0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_drop_addr <= w_drop_next;
            r_valid     <= w_valid_next;
            if (w_load_buf) begin
                r_pc_out <= w_pc_inc;
                r_instr  <= memRdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // memReq is gated by rst directly so no request is seen during reset,
    // matching the memory side which abandons its transaction on the same rst.
    assign memReq         = !rst && ((r_state == S_REQ) || (r_state == S_DROP));
    assign memAddr        = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign pcOut          = r_pc_out;
    assign instructionOut = r_instr;
    assign valid          = r_valid;

endmodule

// File: tb/tb_if_stage_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_stage_fetch
//
// Scripted memory responses drive if_stage_fetch through sequential fetch,
// wait states, freeze, redirects in every state, reset mid-wait and PC wrap.
// Each accepted fetch pushes its expected {pcOut, instructionOut} onto a
// scoreboard; a monitor pops one entry per new instruction (valid 0->1).
// ---------------------------------------------------------------------------
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic [31:0] pcOut;
    logic [31:0] instructionOut;
    logic        valid;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic        prev_valid = 1'b0;

    if_stage_fetch #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branchTaken   (branchTaken),
        .branchAddr    (branchAddr),
        .memReq        (memReq),
        .memAddr       (memAddr),
        .memAck        (memAck),
        .memRdata      (memRdata),
        .pcOut         (pcOut),
        .instructionOut(instructionOut),
        .valid         (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: return at the falling edge, where outputs are settled.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Scoreboard consumer: each fresh instruction must match the next entry.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_instr", {pcOut, instructionOut}, 64'hx);
            end else begin
                check("sb_instr", {pcOut, instructionOut}, sb.pop_front());
            end
        end
        prev_valid = valid;
    end

    // Zero-wait fetch of addr returning addr as data; starts and ends in REQ.
    task automatic fetch0(input logic [31:0] addr);
        check("req_addr", 64'(memAddr), 64'(addr));
        check("req_on", 64'(memReq), 64'd1);
        check("req_valid", 64'(valid), 64'd0);
        sb.push_back({addr + 32'd4, addr});
        memAck   = 1'b1;
        memRdata = addr;
        cyc();
        memAck = 1'b0;
        check("have_valid", 64'(valid), 64'd1);
        check("have_noreq", 64'(memReq), 64'd0);
        cyc();
    endtask

    initial begin
        rst         = 1'b1;
        freeze      = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = 32'h0;
        memAck      = 1'b0;
        memRdata    = 32'h0;
        cyc();
        cyc();
        check("rst_memReq", 64'(memReq), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_pcOut", 64'(pcOut), 64'd0);
        check("rst_instr", 64'(instructionOut), 64'd0);
        rst = 1'b0;
        cyc();

        // Sequential zero-wait fetches: one instruction every two cycles.
        for (int i = 0; i < 4; i++) fetch0(32'(i * 4));

        // Three-cycle wait at 0x10: address must stay put until ack.
        for (int i = 0; i < 3; i++) begin
            check("wait_addr", 64'(memAddr), 64'h10);
            check("wait_req", 64'(memReq), 64'd1);
            if (i == 2) begin
                sb.push_back({32'h14, 32'h10});
                memAck   = 1'b1;
                memRdata = 32'h10;
            end
            cyc();
            memAck = 1'b0;
        end
        check("wait_valid", 64'(valid), 64'd1);
        check("wait_pcOut", 64'(pcOut), 64'h14);

        // Freeze in HAVE for 4 cycles; a stray ack while idle must be ignored.
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            memAck   = (i == 1);
            memRdata = 32'hBAD0_BAD0;
            cyc();
            memAck = 1'b0;
            check("frz_valid", 64'(valid), 64'd1);
            check("frz_pcOut", 64'(pcOut), 64'h14);
            check("frz_instr", 64'(instructionOut), 64'h10);
            check("frz_noreq", 64'(memReq), 64'd0);
        end
        freeze = 1'b0;
        cyc();
        check("unfrz_valid", 64'(valid), 64'd0);
        check("unfrz_addr", 64'(memAddr), 64'h14);
        fetch0(32'h14);
        fetch0(32'h18);
        fetch0(32'h1C);

        // Branch during a pending request at 0x20: wait it out, drop data.
        check("pend_addr", 64'(memAddr), 64'h20);
        branchTaken = 1'b1;
        branchAddr  = 32'h100;
        cyc();
        branchTaken = 1'b0;
        check("drop_addr", 64'(memAddr), 64'h20);
        check("drop_req", 64'(memReq), 64'd1);
        check("drop_valid", 64'(valid), 64'd0);
        cyc();
        check("drop_addr2", 64'(memAddr), 64'h20);
        memAck   = 1'b1;
        memRdata = 32'hDEAD_BEEF;
        cyc();
        memAck = 1'b0;
        check("drop_done_valid", 64'(valid), 64'd0);
        check("redir_addr", 64'(memAddr), 64'h100);

        // Branch in HAVE while frozen: branch wins.
        sb.push_back({32'h104, 32'h100});
        memAck   = 1'b1;
        memRdata = 32'h100;
        cyc();
        memAck = 1'b0;
        check("bh_valid", 64'(valid), 64'd1);
        freeze      = 1'b1;
        branchTaken = 1'b1;
        branchAddr  = 32'h200;
        cyc();
        branchTaken = 1'b0;
        freeze      = 1'b0;
        check("bf_valid", 64'(valid), 64'd0);
        check("bf_req", 64'(memReq), 64'd1);
        check("bf_addr", 64'(memAddr), 64'h200);

        // Ack and branch together in REQ: data discarded, refetch at target.
        memAck      = 1'b1;
        memRdata    = 32'h200;
        branchTaken = 1'b1;
        branchAddr  = 32'h300;
        cyc();
        memAck      = 1'b0;
        branchTaken = 1'b0;
        check("ab_valid", 64'(valid), 64'd0);
        check("ab_addr", 64'(memAddr), 64'h300);

        // Reset while waiting at 0x40.
        memAck      = 1'b1;
        memRdata    = 32'h300;
        branchTaken = 1'b1;
        branchAddr  = 32'h40;
        cyc();
        memAck      = 1'b0;
        branchTaken = 1'b0;
        cyc();
        check("pre_rst_addr", 64'(memAddr), 64'h40);
        rst = 1'b1;
        #1;
        check("rst_comb_noreq", 64'(memReq), 64'd0);
        memAck   = 1'b1;
        memRdata = 32'h40;
        cyc();
        memAck = 1'b0;
        check("midrst_noreq", 64'(memReq), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        rst = 1'b0;
        cyc();
        check("post_rst_req", 64'(memReq), 64'd1);
        check("post_rst_addr", 64'(memAddr), 64'h0);
        check("post_rst_valid", 64'(valid), 64'd0);

        // PC wrap: fetch at 0xFFFF_FFFC yields pcOut 0 and next request at 0.
        memAck      = 1'b1;
        memRdata    = 32'h0;
        branchTaken = 1'b1;
        branchAddr  = 32'hFFFF_FFFC;
        cyc();
        memAck      = 1'b0;
        branchTaken = 1'b0;
        fetch0(32'hFFFF_FFFC);
        check("wrap_next_addr", 64'(memAddr), 64'h0);
        cyc();
        cyc();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
